// File: rtl/jtcontra_gfx_rom_arb_if.sv
// GFX ROM sharing bus: SCR and OBJ requester channels plus the single SDRAM ROM slot.
// master = fetchers/SDRAM side, slave = arbiter.
interface jtcontra_gfx_rom_arb_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
);
  // tilemap requester
  logic          scr_cs;
  logic [AW-1:0] scr_addr;
  logic          scr_ok;
  logic [DW-1:0] scr_data;
  // object requester
  logic          obj_cs;
  logic [AW-1:0] obj_addr;
  logic          obj_ok;
  logic [DW-1:0] obj_data;
  // SDRAM ROM slot
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic          rom_ok;
  logic [DW-1:0] rom_data;

  modport master (
    output scr_cs, scr_addr, obj_cs, obj_addr, rom_ok, rom_data,
    input  scr_ok, scr_data, obj_ok, obj_data, rom_cs, rom_addr
  );

  modport slave (
    input  scr_cs, scr_addr, obj_cs, obj_addr, rom_ok, rom_data,
    output scr_ok, scr_data, obj_ok, obj_data, rom_cs, rom_addr
  );
endinterface

// File: rtl/jtcontra_gfx_rom_arb.sv
// Shares one SDRAM GFX ROM slot between the 007121 tilemap (SCR) and object (OBJ) fetchers.
// Define JTCONTRA_ARB_STATS_EN to add per-frame grant counters and the peak OBJ stall.
module jtcontra_gfx_rom_arb #(
  parameter int unsigned AW           = 18,
  parameter int unsigned DW           = 16,
  parameter logic [7:0]  OBJ_MAX_WAIT = 8'd32
) (
  input  logic clk,
  input  logic rst,
  input  logic LHBL,
`ifdef JTCONTRA_ARB_STATS_EN
  input  logic        LVBL,
  output logic [15:0] scr_cnt,
  output logic [15:0] obj_cnt,
  output logic [7:0]  stall_max,
`endif
  output logic busy,
  jtcontra_gfx_rom_arb_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT_SCR = 2'd1;
  localparam logic [1:0] GNT_OBJ = 2'd2;
  localparam int unsigned WW     = 8;

  logic [1:0]    state, state_nx;
  logic          rom_cs, rom_cs_nx;
  logic [AW-1:0] rom_addr, rom_addr_nx;
  logic          settle, settle_nx;
  logic          scr_ok, scr_ok_nx;
  logic          obj_ok, obj_ok_nx;
  logic [DW-1:0] scr_data, scr_data_nx;
  logic [DW-1:0] obj_data, obj_data_nx;
  logic          busy_nx;
  logic [WW-1:0] wait_cnt, wait_cnt_nx;
  logic          obj_forced, pick_obj, obj_grant;

  assign bus.rom_cs   = rom_cs;
  assign bus.rom_addr = rom_addr;
  assign bus.scr_ok   = scr_ok;
  assign bus.scr_data = scr_data;
  assign bus.obj_ok   = obj_ok;
  assign bus.obj_data = obj_data;

  // Priority: starved OBJ first, then SCR during active line, OBJ during blanking
  assign obj_forced = (wait_cnt >= OBJ_MAX_WAIT);
  assign pick_obj   = bus.obj_cs && (!bus.scr_cs || obj_forced || !LHBL);
  assign obj_grant  = (state == IDLE) && pick_obj;

  // OBJ starvation counter, saturating
  always_comb begin
    wait_cnt_nx = wait_cnt;
    if (!bus.obj_cs || state == GNT_OBJ || obj_grant) begin
      wait_cnt_nx = '0;
    end else if (wait_cnt != '1) begin
      wait_cnt_nx = wait_cnt + WW'(1);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx    = state;
    rom_cs_nx   = rom_cs;
    rom_addr_nx = rom_addr;
    settle_nx   = settle;
    scr_ok_nx   = 1'b0;
    obj_ok_nx   = 1'b0;
    scr_data_nx = scr_data;
    obj_data_nx = obj_data;
    case (state)
      IDLE: begin
        rom_cs_nx = 1'b0;
        settle_nx = 1'b0;
        if (bus.scr_cs || bus.obj_cs) begin
          rom_cs_nx = 1'b1;
          settle_nx = 1'b1;
          if (pick_obj) begin
            state_nx    = GNT_OBJ;
            rom_addr_nx = bus.obj_addr;
          end else begin
            state_nx    = GNT_SCR;
            rom_addr_nx = bus.scr_addr;
          end
        end
      end
      GNT_SCR: begin
        // a drop beats a coincident rom_ok; an address step restarts the settle window
        if (!bus.scr_cs) begin
          rom_cs_nx = 1'b0;
          settle_nx = 1'b0;
          state_nx  = IDLE;
        end else if (bus.scr_addr != rom_addr) begin
          rom_addr_nx = bus.scr_addr;
          settle_nx   = 1'b1;
        end else if (settle) begin
          settle_nx = 1'b0;
        end else if (bus.rom_ok) begin
          scr_data_nx = bus.rom_data;
          scr_ok_nx   = 1'b1;
          rom_cs_nx   = 1'b0;
          state_nx    = IDLE;
        end
      end
      GNT_OBJ: begin
        if (!bus.obj_cs) begin
          rom_cs_nx = 1'b0;
          settle_nx = 1'b0;
          state_nx  = IDLE;
        end else if (bus.obj_addr != rom_addr) begin
          rom_addr_nx = bus.obj_addr;
          settle_nx   = 1'b1;
        end else if (settle) begin
          settle_nx = 1'b0;
        end else if (bus.rom_ok) begin
          obj_data_nx = bus.rom_data;
          obj_ok_nx   = 1'b1;
          rom_cs_nx   = 1'b0;
          state_nx    = IDLE;
        end
      end
      default: begin
        rom_cs_nx = 1'b0;
        settle_nx = 1'b0;
        state_nx  = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      settle   <= 1'b0;
      scr_ok   <= 1'b0;
      obj_ok   <= 1'b0;
      scr_data <= '0;
      obj_data <= '0;
      busy     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      rom_cs   <= rom_cs_nx;
      rom_addr <= rom_addr_nx;
      settle   <= settle_nx;
      scr_ok   <= scr_ok_nx;
      obj_ok   <= obj_ok_nx;
      scr_data <= scr_data_nx;
      obj_data <= obj_data_nx;
      busy     <= busy_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

`ifdef JTCONTRA_ARB_STATS_EN
  logic        lvbl_l;
  logic [15:0] scr_run, obj_run;
  logic [7:0]  stall_run;

  // Per-frame statistics, published and restarted on the LVBL rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      lvbl_l    <= 1'b0;
      scr_run   <= '0;
      obj_run   <= '0;
      stall_run <= '0;
      scr_cnt   <= '0;
      obj_cnt   <= '0;
      stall_max <= '0;
    end else begin
      lvbl_l <= LVBL;
      if (LVBL && !lvbl_l) begin
        scr_cnt   <= scr_run;
        obj_cnt   <= obj_run;
        stall_max <= stall_run;
        scr_run   <= 16'(scr_ok_nx);
        obj_run   <= 16'(obj_ok_nx);
        stall_run <= wait_cnt;
      end else begin
        if (scr_ok_nx && scr_run != 16'hFFFF) scr_run <= scr_run + 16'd1;
        if (obj_ok_nx && obj_run != 16'hFFFF) obj_run <= obj_run + 16'd1;
        if (wait_cnt > stall_run) stall_run <= wait_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jtcontra_gfx_rom_arb.sv
// Bench for jtcontra_gfx_rom_arb: SDRAM responder model, per-requester data scoreboard,
// and one task per scenario checking grant order, timing and reset behaviour.
module tb_jtcontra_gfx_rom_arb;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam logic [AW-1:0] A_SCR = 18'h00100;
  localparam logic [AW-1:0] A_OBJ = 18'h20200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic LHBL = 1'b1;
  logic busy;
`ifdef JTCONTRA_ARB_STATS_EN
  logic        LVBL = 1'b1;
  logic [15:0] scr_cnt, obj_cnt;
  logic [7:0]  stall_max;
`endif

  always #5 clk = ~clk;

  jtcontra_gfx_rom_arb_if #(.AW(AW), .DW(DW)) bus ();

  jtcontra_gfx_rom_arb #(.AW(AW), .DW(DW), .OBJ_MAX_WAIT(8'd32)) dut (
    .clk  (clk),
    .rst  (rst),
    .LHBL (LHBL),
`ifdef JTCONTRA_ARB_STATS_EN
    .LVBL      (LVBL),
    .scr_cnt   (scr_cnt),
    .obj_cnt   (obj_cnt),
    .stall_max (stall_max),
`endif
    .busy (busy),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // responder controls
  int lat = 3;
  bit ok_force = 1'b0;

  // requester behaviour
  bit scr_auto_drop = 1'b1;
  bit obj_auto_drop = 1'b1;
  bit scr_repeat = 1'b0;

  // scoreboard and event log
  logic [DW-1:0] scr_q[$];
  logic [DW-1:0] obj_q[$];
  int            gnt_cyc[$];
  logic [AW-1:0] gnt_addr[$];
  int cyc = 0;
  int scr_ok_cyc = 0, obj_ok_cyc = 0;
  int scr_ok_n = 0, obj_ok_n = 0;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return (a == 18'h01234) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  function automatic logic [AW-1:0] gaddr(input int i);
    return (i < gnt_addr.size()) ? gnt_addr[i] : 'x;
  endfunction

  function automatic int gcyc(input int i);
    return (i < gnt_cyc.size()) ? gnt_cyc[i] : -1000;
  endfunction

  // SDRAM model: data valid `lat` cycles after rom_cs rises, or held high when forced
  initial begin : responder
    int cnt;
    cnt = 0;
    bus.rom_ok = 1'b0;
    bus.rom_data = '0;
    forever begin
      @(negedge clk);
      if (bus.rom_cs === 1'b1) cnt++;
      else cnt = 0;
      bus.rom_ok = ok_force || (bus.rom_cs === 1'b1 && cnt >= lat);
      bus.rom_data = rom_word(bus.rom_addr);
    end
  end

  // Output monitor: logs grants, pops the scoreboard on every ok pulse
  initial begin : monitor
    logic prev_cs, prev_sok, prev_ook;
    logic [DW-1:0] exp;
    prev_cs = 1'b0; prev_sok = 1'b0; prev_ook = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rom_cs === 1'b1 && !prev_cs) begin
        gnt_cyc.push_back(cyc);
        gnt_addr.push_back(bus.rom_addr);
      end
      prev_cs = (bus.rom_cs === 1'b1);
      if (bus.scr_ok === 1'b1) begin
        scr_ok_n++; scr_ok_cyc = cyc;
        checks++;
        if (prev_sok) begin
          failures++; $display("FAIL scr_ok_pulse: scr_ok high 2 cycles in a row at cycle %0d, required 1-cycle pulse", cyc);
        end else if (!scr_repeat && scr_q.size() == 0) begin
          failures++; $display("FAIL scr_ok_unexpected: scr_ok=1 at cycle %0d, required 0", cyc);
        end else begin
          exp = scr_repeat ? rom_word(bus.scr_addr) : scr_q.pop_front();
          if (bus.scr_data !== exp) begin
            failures++; $display("FAIL scr_data: got %h required %h at cycle %0d", bus.scr_data, exp, cyc);
          end
        end
      end
      prev_sok = (bus.scr_ok === 1'b1);
      if (bus.obj_ok === 1'b1) begin
        obj_ok_n++; obj_ok_cyc = cyc;
        checks++;
        if (prev_ook) begin
          failures++; $display("FAIL obj_ok_pulse: obj_ok high 2 cycles in a row at cycle %0d, required 1-cycle pulse", cyc);
        end else if (obj_q.size() == 0) begin
          failures++; $display("FAIL obj_ok_unexpected: obj_ok=1 at cycle %0d, required 0", cyc);
        end else begin
          exp = obj_q.pop_front();
          if (bus.obj_data !== exp) begin
            failures++; $display("FAIL obj_data: got %h required %h at cycle %0d", bus.obj_data, exp, cyc);
          end
        end
      end
      prev_ook = (bus.obj_ok === 1'b1);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: act just after the falling edge; requesters release cs after their ok
  task automatic step();
    @(negedge clk);
    #1;
    if (bus.scr_ok === 1'b1 && scr_auto_drop) bus.scr_cs = 1'b0;
    if (bus.obj_ok === 1'b1 && obj_auto_drop) bus.obj_cs = 1'b0;
  endtask

  task automatic clear_logs();
    gnt_cyc.delete();
    gnt_addr.delete();
  endtask

  task automatic wait_drain(input int bound, output bit done);
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (scr_q.size() == 0 && obj_q.size() == 0 && !bus.scr_cs && !bus.obj_cs && busy === 1'b0)
        done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus.rom_cs !== 1'b0) begin failures++; $display("FAIL reset_rom_cs: got %b required 0", bus.rom_cs); end
    checks++; if (bus.rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr: got %h required 0", bus.rom_addr); end
    checks++; if (bus.scr_ok !== 1'b0) begin failures++; $display("FAIL reset_scr_ok: got %b required 0", bus.scr_ok); end
    checks++; if (bus.obj_ok !== 1'b0) begin failures++; $display("FAIL reset_obj_ok: got %b required 0", bus.obj_ok); end
    checks++; if (bus.scr_data !== '0) begin failures++; $display("FAIL reset_scr_data: got %h required 0", bus.scr_data); end
    checks++; if (bus.obj_data !== '0) begin failures++; $display("FAIL reset_obj_data: got %h required 0", bus.obj_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_scr_only();
    bit done;
    int n0, o0;
    clear_logs();
    lat = 3;
    n0 = scr_ok_n; o0 = obj_ok_n;
    scr_q.push_back(16'hBEEF);
    bus.scr_addr = 18'h01234;
    bus.scr_cs = 1'b1;
    wait_drain(40, done);
    checks++; if (!done) begin failures++; $display("FAIL scr_only_timeout: transaction not finished within 40 cycles"); end
    checks++; if (gnt_addr.size() != 1 || gaddr(0) !== 18'h01234) begin
      failures++; $display("FAIL scr_only_grant: grants=%0d addr=%h required 1 grant at 01234", gnt_addr.size(), gaddr(0)); end
    checks++; if (scr_ok_n - n0 != 1) begin failures++; $display("FAIL scr_only_ok_count: got %0d required 1", scr_ok_n - n0); end
    checks++; if (obj_ok_n != o0) begin failures++; $display("FAIL scr_only_obj_ok: got %0d obj_ok pulses required 0", obj_ok_n - o0); end
    checks++; if (scr_ok_cyc - gcyc(0) != 3) begin
      failures++; $display("FAIL scr_only_latency: grant-to-ok got %0d required 3", scr_ok_cyc - gcyc(0)); end
    repeat (4) step();
    checks++; if (bus.scr_data !== 16'hBEEF) begin failures++; $display("FAIL scr_data_hold: got %h required beef", bus.scr_data); end
  endtask

  task automatic test_both(input logic lhbl);
    bit done;
    int first_ok;
    clear_logs();
    lat = 3;
    LHBL = lhbl;
    scr_q.push_back(rom_word(A_SCR));
    obj_q.push_back(rom_word(A_OBJ));
    bus.scr_addr = A_SCR; bus.obj_addr = A_OBJ;
    bus.scr_cs = 1'b1; bus.obj_cs = 1'b1;
    wait_drain(60, done);
    first_ok = lhbl ? scr_ok_cyc : obj_ok_cyc;
    checks++; if (!done) begin failures++; $display("FAIL both_timeout(LHBL=%b): not finished within 60 cycles", lhbl); end
    checks++; if (gnt_addr.size() != 2 || gaddr(0) !== (lhbl ? A_SCR : A_OBJ)) begin
      failures++; $display("FAIL both_first(LHBL=%b): grants=%0d first=%h required %h", lhbl, gnt_addr.size(), gaddr(0), lhbl ? A_SCR : A_OBJ); end
    checks++; if (gaddr(1) !== (lhbl ? A_OBJ : A_SCR)) begin
      failures++; $display("FAIL both_second(LHBL=%b): got %h required %h", lhbl, gaddr(1), lhbl ? A_OBJ : A_SCR); end
    checks++; if (gcyc(1) - first_ok != 1) begin
      failures++; $display("FAIL both_idle_gap(LHBL=%b): second grant %0d cycles after first ok, required 1", lhbl, gcyc(1) - first_ok); end
    LHBL = 1'b1;
  endtask

  task automatic test_starvation();
    bit done;
    int obj_edge, scr_before;
    clear_logs();
    lat = 3;
    LHBL = 1'b1;
    scr_repeat = 1'b1;
    scr_auto_drop = 1'b0;
    obj_q.push_back(rom_word(A_OBJ));
    bus.scr_addr = A_SCR; bus.obj_addr = A_OBJ;
    bus.scr_cs = 1'b1; bus.obj_cs = 1'b1;
    obj_edge = -1;
    for (int k = 1; k <= 200 && bus.scr_cs; k++) begin
      step();
      if (obj_edge < 0 && bus.rom_cs === 1'b1 && bus.rom_addr === A_OBJ) obj_edge = k - 1;
      if (obj_q.size() == 0) bus.scr_cs = 1'b0;
    end
    bus.scr_cs = 1'b0;
    wait_drain(20, done);
    scr_repeat = 1'b0;
    scr_auto_drop = 1'b1;
    scr_before = 0;
    for (int i = 0; i < gnt_addr.size() && gnt_addr[i] !== A_OBJ; i++) scr_before++;
    // SCR cycles every 4 clocks; wait_cnt first reaches 32 at an IDLE decision on edge 32
    checks++; if (obj_edge != 32) begin failures++; $display("FAIL starve_grant_edge: OBJ granted on edge %0d, required 32", obj_edge); end
    checks++; if (scr_before != 8) begin failures++; $display("FAIL starve_scr_grants: got %0d SCR grants before OBJ, required 8", scr_before); end
    checks++; if (!done) begin failures++; $display("FAIL starve_drain: OBJ result not delivered"); end
  endtask

  task automatic test_stale_ok();
    bit done;
    clear_logs();
    ok_force = 1'b1;
    LHBL = 1'b1;
    scr_q.push_back(rom_word(A_SCR));
    obj_q.push_back(rom_word(A_OBJ));
    bus.scr_addr = A_SCR; bus.obj_addr = A_OBJ;
    bus.scr_cs = 1'b1; bus.obj_cs = 1'b1;
    wait_drain(40, done);
    ok_force = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL stale_timeout: not finished within 40 cycles"); end
    checks++; if (gaddr(1) !== A_OBJ) begin failures++; $display("FAIL stale_order: second grant %h required %h", gaddr(1), A_OBJ); end
    checks++; if (obj_ok_cyc - gcyc(1) < 2) begin
      failures++; $display("FAIL stale_obj_latency: obj_ok %0d cycles after grant, required >=2", obj_ok_cyc - gcyc(1)); end
    checks++; if (scr_ok_cyc - gcyc(0) < 2) begin
      failures++; $display("FAIL stale_scr_latency: scr_ok %0d cycles after grant, required >=2", scr_ok_cyc - gcyc(0)); end
    step();
  endtask

  task automatic test_drop();
    bit done;
    int o0, n0;
    clear_logs();
    lat = 6;
    o0 = obj_ok_n;
    bus.obj_addr = A_OBJ;
    bus.obj_cs = 1'b1;
    for (int i = 0; i < 10 && bus.rom_cs !== 1'b1; i++) step();
    checks++; if (bus.rom_cs !== 1'b1) begin failures++; $display("FAIL drop_grant: rom_cs got %b required 1", bus.rom_cs); end
    step();
    bus.obj_cs = 1'b0;
    step();
    checks++; if (bus.rom_cs !== 1'b0) begin failures++; $display("FAIL drop_rom_cs: got %b required 0", bus.rom_cs); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy: got %b required 0", busy); end
    repeat (8) step();
    checks++; if (obj_ok_n != o0) begin failures++; $display("FAIL drop_obj_ok: got %0d pulses required 0", obj_ok_n - o0); end
    lat = 3;
    n0 = scr_ok_n;
    scr_q.push_back(rom_word(A_SCR));
    bus.scr_addr = A_SCR;
    bus.scr_cs = 1'b1;
    wait_drain(30, done);
    checks++; if (!done || scr_ok_n - n0 != 1) begin
      failures++; $display("FAIL drop_next_scr: done=%b scr_ok pulses=%0d required 1", done, scr_ok_n - n0); end
    checks++; if (gaddr(gnt_addr.size() - 1) !== A_SCR) begin
      failures++; $display("FAIL drop_next_addr: got %h required %h", gaddr(gnt_addr.size() - 1), A_SCR); end
  endtask

  task automatic test_ok_vs_drop();
    int o0;
    clear_logs();
    lat = 3;
    o0 = obj_ok_n;
    bus.obj_addr = 18'h20300;
    bus.obj_cs = 1'b1;
    for (int i = 0; i < 20 && bus.rom_ok !== 1'b1; i++) step();
    checks++; if (bus.rom_ok !== 1'b1) begin failures++; $display("FAIL okdrop_setup: rom_ok got %b required 1", bus.rom_ok); end
    bus.obj_cs = 1'b0;
    step();
    checks++; if (bus.rom_cs !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL okdrop_release: rom_cs=%b busy=%b required 0 0", bus.rom_cs, busy); end
    repeat (4) step();
    checks++; if (obj_ok_n != o0) begin failures++; $display("FAIL okdrop_obj_ok: got %0d pulses required 0", obj_ok_n - o0); end
  endtask

  task automatic test_reset_mid();
    int n0, o0;
    clear_logs();
    lat = 6;
    n0 = scr_ok_n; o0 = obj_ok_n;
    bus.scr_addr = A_SCR;
    bus.scr_cs = 1'b1;
    for (int i = 0; i < 10 && bus.rom_cs !== 1'b1; i++) step();
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_pending: busy got %b required 1", busy); end
    rst = 1'b1;
    step();
    checks++; if (bus.rom_cs !== 1'b0) begin failures++; $display("FAIL rstmid_rom_cs: got %b required 0", bus.rom_cs); end
    checks++; if (bus.scr_ok !== 1'b0) begin failures++; $display("FAIL rstmid_scr_ok: got %b required 0", bus.scr_ok); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    checks++; if (bus.rom_addr !== '0) begin failures++; $display("FAIL rstmid_rom_addr: got %h required 0", bus.rom_addr); end
    checks++; if (bus.scr_data !== '0) begin failures++; $display("FAIL rstmid_scr_data: got %h required 0", bus.scr_data); end
    bus.scr_cs = 1'b0;
    rst = 1'b0;
    ok_force = 1'b1;
    repeat (5) step();
    ok_force = 1'b0;
    step();
    checks++; if (scr_ok_n != n0 || obj_ok_n != o0) begin
      failures++; $display("FAIL rstmid_late_ok: scr_ok pulses=%0d obj_ok pulses=%0d required 0 0", scr_ok_n - n0, obj_ok_n - o0); end
  endtask

  initial begin
    bus.scr_cs = 1'b0; bus.scr_addr = '0;
    bus.obj_cs = 1'b0; bus.obj_addr = '0;
    test_reset();
    test_scr_only();
    test_both(1'b1);
    test_both(1'b0);
    test_starvation();
    test_stale_ok();
    test_drop();
    test_ok_vs_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
